player_bullet_ctrl: RTL
=======================

Name: player_bullet_ctrl

Overview:
- Upstream of the enemy formation block: produces the single player bullet position (bulletPosX/bulletPosY) that every enemy tests for collision.
- Consumes the formation's OR-ed collision output to retire the bullet and keeps a 2-digit BCD hit score.
- Renders the bullet sprite as a 6-bit rgbContent layer, OR-ed into the frame alongside the enemy layer.

Parameters:
- TICK_DIV, 250000: clk cycles per movement tick; internal divider.
- SPEED, 4: pixels the bullet moves up per tick.
- TOP_LIMIT, 8: bullet retires when posY < TOP_LIMIT + SPEED at a tick.
- BW, 2: bullet width in pixels.
- BH, 6: bullet height in pixels.
- MUZZLE_DY, 8: spawn Y = playerPosY - MUZZLE_DY.
- COOLDOWN_TICKS, 8: ticks after retire before the next fire is accepted.
- color, 6'b111111: bullet pixel colour.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- fire  input  1  raw fire button, asynchronous to clk.
- playerPosX  input  10  player sprite X (top-left).
- playerPosY  input  10  player sprite Y (top-left).
- collision  input  1  OR of all enemy collision flags, level.
- horCnt  input  10  VGA horizontal pixel counter.
- verCnt  input  10  VGA vertical pixel counter.
- bulletPosX  output  10  bullet X; 10'd1023 when parked.
- bulletPosY  output  10  bullet Y; 10'd1023 when parked.
- bulletActive  output  1  high in FLIGHT only.
- score  output  8  BCD score {tens, ones}.
- rgbContent  output  6  bullet pixel colour, else 6'b000000.

Behaviour:
Reset (reset low, asynchronous):
- State IDLE, divider 0, cooldown 0, score 8'h00.
- bulletPosX = bulletPosY = 10'd1023; bulletActive 0.
- Synchronizer and edge-detect flops cleared.

Fire input:
- 2-flop synchronizer, then rising-edge detect giving fire_pulse (1 cycle).
- Fire is accepted 3 clk cycles after the raw rising edge.

Tick:
- Divider counts 0..TICK_DIV-1; tick=1 for one cycle when count wraps.
- Divider free-runs in all states.

States:
- IDLE: bullet parked.
  - fire_pulse → FLIGHT on the next edge.
  - Load bulletPosX = playerPosX + 3, bulletPosY = playerPosY - MUZZLE_DY (10-bit, no wrap check; player Y is always ≥ 16).
- FLIGHT: bulletActive=1.
  - Priority 1: collision=1 sampled at a clk edge → score +1, park position, cooldown = COOLDOWN_TICKS, go COOLDOWN.
  - Priority 2: else on tick, if bulletPosY < TOP_LIMIT+SPEED → park, cooldown = COOLDOWN_TICKS, go COOLDOWN (no score).
  - Otherwise on tick, bulletPosY -= SPEED.
  - bulletPosX does not change in flight.
  - Collision and tick in the same cycle: collision wins.
- COOLDOWN: bullet parked.
  - Decrement cooldown on each tick; reaching 0 → IDLE.
  - fire_pulse here is discarded, not queued.

Score:
- BCD increment: ones 9→0 with carry into tens.
- Saturates at 8'h99; a hit at 99 keeps 99.
- Increments exactly once per FLIGHT→COOLDOWN-by-collision transition, even if collision stays high multiple cycles.

Render (combinational):
- rgbContent = color when state==FLIGHT and bulletPosX ≤ horCnt < bulletPosX+BW and bulletPosY ≤ verCnt < bulletPosY+BH; else 0.

Outputs:
- All outputs except rgbContent are registered.
- Parked position is 1023 on both axes so no enemy box can match.

Reset mid-flight: immediate return to IDLE, parked, score cleared.

Test Plan:
1. Reset released, TICK_DIV=4, playerPos=(300,440), fire pulse → after 3 clk cycles FLIGHT, bullet=(303,432); every 4 cycles Y drops by 4 (428, 424, ...); X stays 303.
2. Free flight to top, no collision → at the tick where Y=8 (8 < 12): park (1023,1023), COOLDOWN; IDLE after 8 ticks (32 cycles); score stays 00.
3. Collision held 5 cycles during FLIGHT → score 00→01 once; park next cycle; later fire pulses during cooldown are ignored (bulletActive stays 0).
4. Score preset to 09 via 9 hits, then 1 hit → 10; after 99, another hit → stays 99.
5. Collision asserted in the same cycle as tick → collision path taken: score increments, Y not decremented, park.
6. Render at bullet (100,200), BW=2, BH=6: (100,200) and (101,205) → 6'b111111; (102,200) and (100,206) → 0; in IDLE → 0 everywhere. Async reset mid-flight → outputs reset without a clk edge.

Source files
------------

// File: rtl/player_bullet_ctrl.sv
// Player bullet: fire synchroniser, movement tick divider, flight/cooldown FSM,
// BCD hit score and combinational sprite render for the bullet layer.
module player_bullet_ctrl #(
    parameter int unsigned TICK_DIV       = 250000,
    parameter int unsigned SPEED          = 4,
    parameter int unsigned TOP_LIMIT      = 8,
    parameter int unsigned BW             = 2,
    parameter int unsigned BH             = 6,
    parameter int unsigned MUZZLE_DY      = 8,
    parameter int unsigned COOLDOWN_TICKS = 8,
    parameter logic [5:0]  color          = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] playerPosX,
    input  logic [9:0] playerPosY,
    input  logic       collision,
    input  logic [9:0] horCnt,
    input  logic [9:0] verCnt,
    output logic [9:0] bulletPosX,
    output logic [9:0] bulletPosY,
    output logic       bulletActive,
    output logic [7:0] score,
    output logic [5:0] rgbContent
);

    localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CoolW = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [9:0]  Parked = 10'd1023;

    typedef enum logic [1:0] {StIdle, StFlight, StCooldown} state_t;

    state_t            stateQ, stateD;
    logic [DivW-1:0]   divCnt;
    logic              tick;
    logic              fireSync1, fireSync2, fireDly, firePulse;
    logic [9:0]        posXQ, posXD, posYQ, posYD;
    logic [CoolW-1:0]  coolQ, coolD;
    logic [7:0]        scoreQ, scoreD, scoreInc;
    logic              hitX, hitY;

    assign tick      = (divCnt == DivW'(TICK_DIV - 1));
    assign firePulse = fireSync2 & ~fireDly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt    <= '0;
            fireSync1 <= 1'b0;
            fireSync2 <= 1'b0;
            fireDly   <= 1'b0;
            stateQ    <= StIdle;
            posXQ     <= Parked;
            posYQ     <= Parked;
            coolQ     <= '0;
            scoreQ    <= 8'h00;
        end else begin
            divCnt    <= tick ? '0 : divCnt + DivW'(1);
            fireSync1 <= fire;
            fireSync2 <= fireSync1;
            fireDly   <= fireSync2;
            stateQ    <= stateD;
            posXQ     <= posXD;
            posYQ     <= posYD;
            coolQ     <= coolD;
            scoreQ    <= scoreD;
        end
    end

    // Saturating two-digit BCD increment
    always_comb begin
        scoreInc = scoreQ;
        if (scoreQ != 8'h99) begin
            if (scoreQ[3:0] == 4'd9) begin
                scoreInc = {scoreQ[7:4] + 4'd1, 4'd0};
            end else begin
                scoreInc[3:0] = scoreQ[3:0] + 4'd1;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        posXD  = posXQ;
        posYD  = posYQ;
        coolD  = coolQ;
        scoreD = scoreQ;
        unique case (stateQ)
            StIdle: begin
                if (firePulse) begin
                    stateD = StFlight;
                    posXD  = playerPosX + 10'd3;
                    posYD  = playerPosY - 10'(MUZZLE_DY);
                end
            end
            StFlight: begin
                // Collision outranks the tick so a hit is never lost to a move
                if (collision) begin
                    scoreD = scoreInc;
                    posXD  = Parked;
                    posYD  = Parked;
                    coolD  = CoolW'(COOLDOWN_TICKS);
                    stateD = StCooldown;
                end else if (tick) begin
                    if (posYQ < 10'(TOP_LIMIT + SPEED)) begin
                        posXD  = Parked;
                        posYD  = Parked;
                        coolD  = CoolW'(COOLDOWN_TICKS);
                        stateD = StCooldown;
                    end else begin
                        posYD = posYQ - 10'(SPEED);
                    end
                end
            end
            StCooldown: begin
                if (tick) begin
                    if (coolQ <= CoolW'(1)) begin
                        coolD  = '0;
                        stateD = StIdle;
                    end else begin
                        coolD = coolQ - CoolW'(1);
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign bulletPosX   = posXQ;
    assign bulletPosY   = posYQ;
    assign bulletActive = (stateQ == StFlight);
    assign score        = scoreQ;

    // 11-bit compares so the right/bottom edge cannot wrap
    assign hitX = ({1'b0, horCnt} >= {1'b0, posXQ}) &&
                  ({1'b0, horCnt} <  ({1'b0, posXQ} + 11'(BW)));
    assign hitY = ({1'b0, verCnt} >= {1'b0, posYQ}) &&
                  ({1'b0, verCnt} <  ({1'b0, posYQ} + 11'(BH)));

    assign rgbContent = (bulletActive && hitX && hitY) ? color : 6'b000000;

endmodule
